inst_mem_sync: RTL and testbench

//  Parametrised, synchronous instruction memory that replaces the fixed 32-word combinational ROM.
//  - Depth and width are parameters.
//  - Reads are registered, with a valid/ready handshake on both the request and response sides.
//  - A program port loads contents at run time.
//  - Misaligned and out-of-range fetches are flagged as faults.
//  - Sits between the fetch stage and the decode stage.

---
 rtl/inst_mem_sync.sv | 113 +++++++++++
 tb/tb_inst_mem_sync.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_sync.sv
// inst_mem_sync: parametrised synchronous instruction memory.
// Fetch side is a valid/ready request with a registered response (1-cycle
// latency, full throughput while the consumer is ready). A program port
// loads words at run time and always wins over a fetch in the same cycle.
// Misaligned or out-of-range byte addresses return a NOP with rsp_fault set.
// Optional feature macro: INST_MEM_PARITY_EN (per-word even parity, rsp_perr).
module inst_mem_sync #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_inst,
  output logic                  rsp_fault,
  output logic                  rsp_perr,
  input  logic                  prog_we,
  input  logic [DEPTH_LOG2-1:0] prog_addr,
  input  logic [DATA_W-1:0]     prog_data,
  input  logic                  prog_pflip
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Storage is deliberately outside the reset domain: rst only flushes the
  // response pipeline, program contents survive it.
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_inst_q,  rsp_inst_d;
  logic                  rsp_fault_q, rsp_fault_d;
  logic                  accept;
  logic                  fault;
  logic [DEPTH_LOG2-1:0] idx;

  // A write cycle blocks fetches, so a read never races a write to the array.
  assign req_ready = !rst && !prog_we && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[DEPTH_LOG2+1:2];
  // Any address bit above the word index set means past the end; no aliasing.
  assign fault     = (req_addr[1:0] != 2'b00) ||
                     ((req_addr >> (DEPTH_LOG2 + 2)) != '0);

  // Program port: write at the edge, ignored while in reset.
  always_ff @(posedge clk) begin
    if (prog_we && !rst) mem_q[prog_addr] <= prog_data;
  end

  // Response next-state: load on accept, drop valid once consumed, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_inst_d  = rsp_inst_q;
    rsp_fault_d = rsp_fault_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = fault;
      rsp_inst_d  = fault ? '0 : mem_q[idx];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_inst  = rsp_inst_q;
  assign rsp_fault = rsp_fault_q;

`ifdef INST_MEM_PARITY_EN
  logic par_q [DEPTH];
  logic rsp_perr_q, rsp_perr_d;

  // Parity store; prog_pflip lets software plant a bad parity bit.
  always_ff @(posedge clk) begin
    if (prog_we && !rst) par_q[prog_addr] <= (^prog_data) ^ prog_pflip;
  end

  // Parity check only on a real read; a faulted fetch never touches memory.
  always_comb begin
    rsp_perr_d = rsp_perr_q;
    if (accept) rsp_perr_d = !fault && ((^mem_q[idx]) != par_q[idx]);
  end

  // Parity flag registered alongside the rest of the response.
  always_ff @(posedge clk) begin
    if (rst) rsp_perr_q <= 1'b0;
    else     rsp_perr_q <= rsp_perr_d;
  end

  assign rsp_perr = rsp_perr_q;
`else
  logic unused_pflip;
  assign unused_pflip = prog_pflip;
  assign rsp_perr     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_sync.sv
// Scoreboard bench for inst_mem_sync: the driver pushes the expected response
// for each accepted fetch; an independent monitor pops and compares whenever
// a response is consumed. Reference memory is a plain array indexed by addr/4.
module tb_inst_mem_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_addr, rsp_inst, prog_data;
  logic        rsp_fault, rsp_perr, prog_we, prog_pflip;
  logic [4:0]  prog_addr;

  inst_mem_sync #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
    .rsp_fault(rsp_fault), .rsp_perr(rsp_perr),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_pflip(prog_pflip)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] ref_mem  [32];
  logic        ref_flip [32];
  logic [33:0] exp_q [$];
  logic        rst_cmd = 1'b1;
  logic        acc;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  // Expected {inst, fault, perr} straight from the addressing rules.
  function automatic logic [33:0] expect_of(input logic [31:0] a);
    logic        f;
    logic [31:0] w;
    logic        p;
    f = (a % 4 != 0) || (a >= 32 * 4);
    w = 32'h0;
    p = 1'b0;
    if (!f) begin
      w = ref_mem[a / 4];
`ifdef INST_MEM_PARITY_EN
      p = ref_flip[a / 4];
`endif
    end
    return {w, f, p};
  endfunction

  // One cycle: drive just after negedge, decide acceptance before posedge.
  task automatic step(input logic v, input logic [31:0] a, input logic rr,
                      input logic we, input logic [4:0] pa, input logic [31:0] pd,
                      input logic pf);
    @(negedge clk); #1;
    rst = rst_cmd; req_valid = v; req_addr = a; rsp_ready = rr;
    prog_we = we; prog_addr = pa; prog_data = pd; prog_pflip = pf;
    #1;
    acc = v && req_ready;
    if (acc) exp_q.push_back(expect_of(a));
    if (we && !rst_cmd) begin
      ref_mem[pa]  = pd;
      ref_flip[pa] = pf;
    end
  endtask

  task automatic wr(input logic [4:0] pa, input logic [31:0] pd, input logic pf);
    step(1'b0, 32'h0, 1'b1, 1'b1, pa, pd, pf);
  endtask

  task automatic fetch(input logic [31:0] a);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, a, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      if (acc) return;
    end
    chk("fetch accept timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  // Monitor: a response is consumed when valid & ready just before the edge.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rsp unexpected: got %h with no pending fetch", rsp_inst);
        end else begin
          chk("rsp {inst,fault,perr}", {30'd0, rsp_inst, rsp_fault, rsp_perr},
              {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_pflip = 1'b0;

    // Reset state; a write during reset must not land.
    step(1'b1, 32'h0, 1'b0, 1'b1, 5'd9, 32'h11111111, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_inst",  rsp_inst,  0);
    chk("reset rsp_fault", rsp_fault, 0);
    chk("reset rsp_perr",  rsp_perr,  0);
    chk("reset req_ready", req_ready, 0);
    rst_cmd = 1'b0;

    // Fill every word so no fetch ever reads unprogrammed storage.
    for (int i = 0; i < 32; i++) wr(i[4:0], $urandom, 1'b0);

    // Directed program and back-to-back fetch.
    wr(5'd0, 32'h8C010003, 1'b0);
    wr(5'd1, 32'h8C020004, 1'b0);
    wr(5'd2, 32'h00201820, 1'b0);
    wr(5'd3, 32'h00402020, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("b2b accept", acc, 1);
    end
    idle(2);

    // Faults: misaligned, first out-of-range, plus last in-range word.
    fetch(32'h00000002);
    fetch(32'h00000080);
    fetch(32'h0000007C);
    fetch(32'h80000000);
    idle(2);

    // Back-pressure: response must hold and nothing new may be accepted.
    fetch(32'h00000004);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("hold req_ready", req_ready, 0);
      chk("hold rsp_valid", rsp_valid, 1);
      chk("hold rsp_inst",  rsp_inst,  64'h8C020004);
    end
    fetch(32'h8);
    idle(2);

    // Write priority and write-then-read.
    step(1'b1, 32'h14, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    chk("write blocks fetch", req_ready, 0);
    step(1'b1, 32'h14, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("fetch after write accept", acc, 1);
    idle(2);

    // Reset right after an accept drops the response; a write in reset is lost.
    step(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    rst_cmd = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0);
    chk("reset req_ready", req_ready, 0);
    exp_q.delete();
    rst_cmd = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reset drops rsp", rsp_valid, 0);
    fetch(32'h0);
    fetch(32'h4);
    idle(2);

`ifdef INST_MEM_PARITY_EN
    wr(5'd7, 32'hCAFEF00D, 1'b1);
    fetch(32'h1C);
    idle(1);
    wr(5'd7, 32'hCAFEF00D, 1'b0);
    fetch(32'h1C);
    idle(2);
`endif

    // Random traffic with random back-pressure and interleaved writes.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int          kind;
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = ($urandom_range(0, 31) * 4) + $urandom_range(1, 3);
      else if (kind == 1) a = $urandom | 32'h00000080;
      else                a = $urandom_range(0, 31) * 4;
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)));
    end
    idle(4);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
